// File: rtl/mac_stop_ctrl.sv
// Sequencer + MAC datapath computing C = A x B against a matrix memory with combinational reads.
// Latency: M*N*(K+1) cycles from the start edge to the DONE cycle (K MAC cycles + 1 WRITE per element).
// Backpressure: none; the memory is always ready. stop aborts a run and suppresses the current write.
//
// Ports:
//   clk, resetn              clock (rising edge), asynchronous active-low reset
//   start, stop              begin a multiply (IDLE only) / abort a running multiply
//   data_in_a, data_in_b     A and B elements returned by the memory in the same cycle
//   row/col_addr_a/b/c       element indices presented to the memory (0 outside MAC/WRITE)
//   matrix_a_re/b_re/c_we    memory read/write enables
//   data_out_c               accumulated C element, valid during WRITE
//   busy, done, stopped      status: running, normal-completion pulse, abort pulse
module mac_stop_ctrl #(
   parameter int M                        = 4,
   parameter int K                        = 4,
   parameter int N                        = 4,
   parameter int DATA_WIDTH_INIT_MATRIX   = 32,
   parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic                                 start,
   input  logic                                 stop,
   input  logic [DATA_WIDTH_INIT_MATRIX-1:0]    data_in_a,
   input  logic [DATA_WIDTH_INIT_MATRIX-1:0]    data_in_b,
   output logic [((M > 1) ? $clog2(M) : 1)-1:0] row_addr_a,
   output logic [((K > 1) ? $clog2(K) : 1)-1:0] col_addr_a,
   output logic [((K > 1) ? $clog2(K) : 1)-1:0] row_addr_b,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] col_addr_b,
   output logic [((M > 1) ? $clog2(M) : 1)-1:0] row_addr_c,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] col_addr_c,
   output logic                                 matrix_a_re,
   output logic                                 matrix_b_re,
   output logic                                 matrix_c_we,
   output logic [DATA_WIDTH_RESULT_MATRIX-1:0]  data_out_c,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 stopped
);

   localparam int W  = DATA_WIDTH_INIT_MATRIX;
   localparam int RW = DATA_WIDTH_RESULT_MATRIX;
   localparam int MW = (M > 1) ? $clog2(M) : 1;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int NW = (N > 1) ? $clog2(N) : 1;

   localparam logic [MW-1:0] I_LAST = MW'(M-1);
   localparam logic [KW-1:0] K_LAST = KW'(K-1);
   localparam logic [NW-1:0] J_LAST = NW'(N-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [MW-1:0]   i_q, i_d;
   logic [KW-1:0]   k_q, k_d;
   logic [NW-1:0]   j_q, j_d;
   logic [RW-1:0]   acc_q, acc_d;
   logic            stopped_q, stopped_d;

   // Full-width product of the zero-extended operands; RW >= 2W so widening never truncates.
   logic [2*W-1:0]  prod;
   assign prod = {{W{1'b0}}, data_in_a} * {{W{1'b0}}, data_in_b};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         i_q       <= '0;
         k_q       <= '0;
         j_q       <= '0;
         acc_q     <= '0;
         stopped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         k_q       <= k_d;
         j_q       <= j_d;
         acc_q     <= acc_d;
         stopped_q <= stopped_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      k_d         = k_q;
      j_d         = j_q;
      acc_d       = acc_q;
      stopped_d   = 1'b0;
      row_addr_a  = '0;
      col_addr_a  = '0;
      row_addr_b  = '0;
      col_addr_b  = '0;
      row_addr_c  = '0;
      col_addr_c  = '0;
      matrix_a_re = 1'b0;
      matrix_b_re = 1'b0;
      matrix_c_we = 1'b0;
      data_out_c  = '0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            // stop outranks start so a simultaneous pair never launches a run
            if (start && !stop) begin
               state_d = S_MAC;
               i_d     = '0;
               k_d     = '0;
               j_d     = '0;
               acc_d   = '0;
            end
         end

         S_MAC: begin
            busy        = 1'b1;
            matrix_a_re = 1'b1;
            matrix_b_re = 1'b1;
            row_addr_a  = i_q;
            col_addr_a  = k_q;
            row_addr_b  = k_q;
            col_addr_b  = j_q;
            row_addr_c  = i_q;
            col_addr_c  = j_q;
            if (stop) begin
               state_d   = S_IDLE;
               stopped_d = 1'b1;
               i_d       = '0;
               k_d       = '0;
               j_d       = '0;
               acc_d     = '0;
            end else begin
               // k==0 restarts the sum so the previous element never leaks in
               acc_d = ((k_q == '0) ? '0 : acc_q) + RW'(prod);
               if (k_q == K_LAST) begin
                  state_d = S_WRITE;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end

         S_WRITE: begin
            busy        = 1'b1;
            row_addr_a  = i_q;
            col_addr_a  = k_q;
            row_addr_b  = k_q;
            col_addr_b  = j_q;
            row_addr_c  = i_q;
            col_addr_c  = j_q;
            data_out_c  = acc_q;
            // gated combinationally so an abort in this cycle never reaches memory
            matrix_c_we = !stop;
            if (stop) begin
               state_d   = S_IDLE;
               stopped_d = 1'b1;
               i_d       = '0;
               k_d       = '0;
               j_d       = '0;
               acc_d     = '0;
            end else if (i_q == I_LAST && j_q == J_LAST) begin
               state_d = S_DONE;
               i_d     = '0;
               k_d     = '0;
               j_d     = '0;
               acc_d   = '0;
            end else begin
               state_d = S_MAC;
               k_d     = '0;
               if (j_q != J_LAST) begin
                  j_d = j_q + 1'b1;
               end else begin
                  j_d = '0;
                  i_d = i_q + 1'b1;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
            i_d     = '0;
            k_d     = '0;
            j_d     = '0;
            acc_d   = '0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      stopped = stopped_q;
   end

endmodule

// File: tb/tb_mac_stop_ctrl.sv
// Randomised scoreboard bench for mac_stop_ctrl on a 2x2x2, 8-bit configuration.
// Stimulus pushes expected C writes / done / stopped cycles; a monitor pops and compares.
// Memory is modelled in the bench with combinational reads and a clocked C write port.
module tb_mac_stop_ctrl;

   localparam int M  = 2;
   localparam int K  = 2;
   localparam int N  = 2;
   localparam int W  = 8;
   localparam int RW = 2*W+$clog2(K);
   localparam int MW = (M > 1) ? $clog2(M) : 1;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int NW = (N > 1) ? $clog2(N) : 1;
   localparam int L  = M*N*(K+1);

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [W-1:0]  data_in_a, data_in_b;
   logic [MW-1:0] row_addr_a, row_addr_c;
   logic [KW-1:0] col_addr_a, row_addr_b;
   logic [NW-1:0] col_addr_b, col_addr_c;
   logic          matrix_a_re, matrix_b_re, matrix_c_we;
   logic [RW-1:0] data_out_c;
   logic          busy, done, stopped;

   mac_stop_ctrl #(
      .M(M), .K(K), .N(N),
      .DATA_WIDTH_INIT_MATRIX(W),
      .DATA_WIDTH_RESULT_MATRIX(RW)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop),
      .data_in_a(data_in_a), .data_in_b(data_in_b),
      .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
      .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
      .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
      .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re), .matrix_c_we(matrix_c_we),
      .data_out_c(data_out_c), .busy(busy), .done(done), .stopped(stopped)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mem_a [M][K];
   logic [W-1:0] mem_b [K][N];
   longint       mem_c [M][N];
   logic         clr_c = 1'b0;
   int           cyc = 0;

   always_comb begin
      data_in_a = mem_a[row_addr_a][col_addr_a];
      data_in_b = mem_b[row_addr_b][col_addr_b];
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (clr_c) begin
         for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
               mem_c[i][j] <= 0;
      end else if (matrix_c_we) begin
         mem_c[row_addr_c][col_addr_c] <= longint'(data_out_c);
      end
   end

   // scoreboard queues
   int     wr_i_q[$], wr_j_q[$];
   longint wr_v_q[$];
   int     done_q[$], stop_q[$];
   string  chk_n[$];
   longint chk_a[$], chk_e[$];

   int errors = 0;
   int checks = 0;
   int busy_total = 0;

   initial begin : monitor
      int     ei, ej, ec;
      longint ev, ca, ce;
      string  cn;
      forever begin
         @(negedge clk);
         if (busy) busy_total++;
         if (matrix_c_we) begin
            checks++;
            if (wr_i_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got write (%0d,%0d)=%0d, required no write", row_addr_c, col_addr_c, data_out_c);
            end else begin
               ei = wr_i_q.pop_front(); ej = wr_j_q.pop_front(); ev = wr_v_q.pop_front();
               if (int'(row_addr_c) != ei || int'(col_addr_c) != ej || longint'(data_out_c) != ev) begin
                  errors++;
                  $display("FAIL c_write: got (%0d,%0d)=%0d, required (%0d,%0d)=%0d", row_addr_c, col_addr_c, data_out_c, ei, ej, ev);
               end
            end
         end
         if (done) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: done at cycle %0d, required none", cyc);
            end else begin
               ec = done_q.pop_front();
               if (cyc != ec) begin
                  errors++;
                  $display("FAIL done_cycle: got %0d, required %0d", cyc, ec);
               end
            end
         end
         if (stopped) begin
            checks++;
            if (stop_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_stopped: stopped at cycle %0d, required none", cyc);
            end else begin
               ec = stop_q.pop_front();
               if (cyc != ec) begin
                  errors++;
                  $display("FAIL stopped_cycle: got %0d, required %0d", cyc, ec);
               end
            end
         end
         while (chk_n.size() > 0) begin
            cn = chk_n.pop_front(); ca = chk_a.pop_front(); ce = chk_e.pop_front();
            checks++;
            if (ca != ce) begin
               errors++;
               $display("FAIL %s: got %0d, required %0d", cn, ca, ce);
            end
         end
      end
   end

   task automatic post(input string nm, input longint act, input longint exp);
      chk_n.push_back(nm);
      chk_a.push_back(act);
      chk_e.push_back(exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) tick();
   endtask

   function automatic longint outs_vec();
      logic [63:0] v;
      v = 64'({data_out_c, row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c,
                matrix_a_re, matrix_b_re, matrix_c_we, busy, done, stopped});
      return longint'(v);
   endfunction

   // kind: 0 = normal run, 1 = stop at offset, 2 = reset at offset (offset counted from the start edge)
   task automatic do_run(input int kind, input int off, input int restart_off);
      longint expc [M][N];
      longint s;
      int     t0, bt0, n_el;
      clr_c = 1'b1;
      tick();
      clr_c = 1'b0;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < K; k++) s += longint'(mem_a[i][k]) * longint'(mem_b[k][j]);
            expc[i][j] = s;
         end
      // an abort during element e (MAC or its WRITE) leaves exactly elements 0..e-1 written
      n_el = (kind == 0) ? M*N : off / (K+1);
      for (int e = 0; e < n_el; e++) begin
         wr_i_q.push_back(e / N);
         wr_j_q.push_back(e % N);
         wr_v_q.push_back(expc[e / N][e % N]);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      t0  = cyc;
      bt0 = busy_total;
      if (kind == 0) begin
         done_q.push_back(t0 + L);
         if (restart_off > 0) begin
            wait_to(t0 + restart_off);
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         wait_to(t0 + L + 3);
         post("busy_cycles", longint'(busy_total - bt0), L);
      end else if (kind == 1) begin
         wait_to(t0 + off);
         stop = 1'b1;
         #1;
         post("we_gated_by_stop", longint'(matrix_c_we), 0);
         stop_q.push_back(t0 + off + 1);
         tick();
         stop = 1'b0;
         post("busy_after_stop", longint'(busy), 0);
         repeat (3) tick();
      end else begin
         wait_to(t0 + off);
         resetn = 1'b0;
         #1;
         post("outs_at_reset", outs_vec(), 0);
         tick();
         tick();
         post("outs_held_reset", outs_vec(), 0);
         resetn = 1'b1;
         repeat (3) tick();
      end
      post("pending_writes", longint'(wr_i_q.size()), 0);
      post("pending_done", longint'(done_q.size()), 0);
      post("pending_stopped", longint'(stop_q.size()), 0);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            post($sformatf("mem_c[%0d][%0d]", i, j), mem_c[i][j], ((i*N + j) < n_el) ? expc[i][j] : 0);
   endtask

   task automatic load_basic();
      mem_a[0][0] = 8'd1; mem_a[0][1] = 8'd2; mem_a[1][0] = 8'd3; mem_a[1][1] = 8'd4;
      mem_b[0][0] = 8'd5; mem_b[0][1] = 8'd6; mem_b[1][0] = 8'd7; mem_b[1][1] = 8'd8;
   endtask

   task automatic load_fill(input bit rnd);
      for (int i = 0; i < M; i++)
         for (int k = 0; k < K; k++) mem_a[i][k] = rnd ? W'($urandom_range(0, 255)) : 8'hFF;
      for (int k = 0; k < K; k++)
         for (int j = 0; j < N; j++) mem_b[k][j] = rnd ? W'($urandom_range(0, 255)) : 8'hFF;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int off;
      load_basic();
      repeat (2) @(posedge clk);
      #1;
      post("outs_in_reset", outs_vec(), 0);
      resetn = 1'b1;
      tick();

      // basic 2x2x2: C=[[19,22],[43,50]], done 12 edges after start
      post("model_c00_basic", longint'(mem_a[0][0])*mem_b[0][0] + longint'(mem_a[0][1])*mem_b[1][0], 19);
      do_run(0, 0, 0);

      // all-ones operands: 255*255*2 needs the top accumulator bit
      load_fill(1'b0);
      do_run(0, 0, 0);

      // random operands
      repeat (3) begin
         load_fill(1'b1);
         do_run(0, 0, 0);
      end

      // abort during the MAC phase of element (1,0)
      load_basic();
      off = 2*(K+1) + int'($urandom_range(0, K-1));
      do_run(1, off, 0);

      // stop exactly in a WRITE cycle of a random element
      load_fill(1'b1);
      off = int'($urandom_range(0, M*N-1))*(K+1) + K;
      do_run(1, off, 0);

      // start re-pulsed mid-run is ignored
      load_basic();
      do_run(0, 0, 5);

      // start together with stop in IDLE does nothing
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      repeat (4) begin
         post("idle_start_stop_outs", outs_vec(), 0);
         tick();
      end

      // async reset in the WRITE cycle of element (0,1), then a clean rerun
      do_run(2, 1*(K+1) + K, 0);
      do_run(0, 0, 0);

      repeat (2) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
